// File: rtl/gpr_wb_arbiter.sv
// Two-requester register-file write-back arbiter with a pending-write scoreboard.
// ALU (requester 0) and LSU (requester 1) compete round-robin for a single
// register-file write port. The issue stage reserves destination registers,
// and the decode stage queries them for hazards. A flush drops all reservations.
module gpr_wb_arbiter #(
   parameter int GPR_WIDTH      = 32,
   parameter int GPR_ADDR_SPACE = 5,
   parameter int GPR_NUM        = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      req0_valid_i,
   input  logic [GPR_ADDR_SPACE-1:0] req0_addr_i,
   input  logic [GPR_WIDTH-1:0]      req0_val_i,
   output logic                      req0_ready_o,
   input  logic                      req1_valid_i,
   input  logic [GPR_ADDR_SPACE-1:0] req1_addr_i,
   input  logic [GPR_WIDTH-1:0]      req1_val_i,
   output logic                      req1_ready_o,
   input  logic                      rsv_valid_i,
   input  logic [GPR_ADDR_SPACE-1:0] rsv_addr_i,
   input  logic [GPR_ADDR_SPACE-1:0] rs1_addr_i,
   input  logic [GPR_ADDR_SPACE-1:0] rs2_addr_i,
   output logic                      rs1_busy_o,
   output logic                      rs2_busy_o,
   input  logic                      flush_i,
   output logic                      rd_we_o,
   output logic [GPR_ADDR_SPACE-1:0] rd_addr_o,
   output logic [GPR_WIDTH-1:0]      rd_val_o
);

   // Priority pointer: 0 prefers the ALU, 1 prefers the LSU.
   logic                      ptr;
   logic [GPR_NUM-1:0]        pending;
   logic [GPR_NUM-1:0]        pending_next;
   logic                      grant0;
   logic                      grant1;
   logic                      xfer;
   logic [GPR_ADDR_SPACE-1:0] win_addr;
   logic [GPR_WIDTH-1:0]      win_val;

   // Round-robin grant: the pointed requester wins when valid, else the other one.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!flush_i) begin
         if (!ptr) begin
            grant0 = req0_valid_i;
            grant1 = req1_valid_i & ~req0_valid_i;
         end else begin
            grant1 = req1_valid_i;
            grant0 = req0_valid_i & ~req1_valid_i;
         end
      end
   end

   assign req0_ready_o = grant0;
   assign req1_ready_o = grant1;
   assign xfer         = grant0 | grant1;
   assign win_addr     = grant1 ? req1_addr_i : req0_addr_i;
   assign win_val      = grant1 ? req1_val_i  : req0_val_i;

   // Next pending vector: flush clears all; otherwise a completed write clears its
   // bit, then a reservation sets its bit, so a same-edge reserve wins. x0 never pends.
   always_comb begin
      pending_next = pending;
      if (flush_i) begin
         pending_next = '0;
      end else begin
         if (xfer) begin
            pending_next[win_addr] = 1'b0;
         end
         if (rsv_valid_i) begin
            pending_next[rsv_addr_i] = 1'b1;
         end
      end
      pending_next[0] = 1'b0;
   end

   // Hazard queries read the registered vector only; there is no same-cycle bypass.
   assign rs1_busy_o = pending[rs1_addr_i];
   assign rs2_busy_o = pending[rs2_addr_i];

   // State update: pointer, pending vector and the registered write port.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ptr       <= 1'b0;
         pending   <= '0;
         rd_we_o   <= 1'b0;
         rd_addr_o <= '0;
         rd_val_o  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values, independent of statement order.
         pending <= pending_next;
         rd_we_o <= xfer && (win_addr != '0);
         if (xfer) begin
            ptr       <= grant0;
            rd_addr_o <= win_addr;
            rd_val_o  <= win_val;
         end
      end
   end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Randomized scoreboard bench for gpr_wb_arbiter. The driver predicts each cycle's
// grants and busy flags from a behavioural model and queues the expected register
// write. A monitor pops that entry one edge later and compares it with the rd_* port.
module tb_gpr_wb_arbiter;

   localparam int W = 32;
   localparam int A = 5;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req1_valid, req0_ready, req1_ready;
   logic [A-1:0] req0_addr, req1_addr;
   logic [W-1:0] req0_val, req1_val;
   logic         rsv_valid;
   logic [A-1:0] rsv_addr, rs1_addr, rs2_addr;
   logic         rs1_busy, rs2_busy, flush;
   logic         rd_we;
   logic [A-1:0] rd_addr;
   logic [W-1:0] rd_val;

   gpr_wb_arbiter #(.GPR_WIDTH(W), .GPR_ADDR_SPACE(A), .GPR_NUM(N)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req0_valid_i(req0_valid), .req0_addr_i(req0_addr), .req0_val_i(req0_val),
      .req0_ready_o(req0_ready),
      .req1_valid_i(req1_valid), .req1_addr_i(req1_addr), .req1_val_i(req1_val),
      .req1_ready_o(req1_ready),
      .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr),
      .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
      .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
      .flush_i(flush),
      .rd_we_o(rd_we), .rd_addr_o(rd_addr), .rd_val_o(rd_val)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         we;
      bit [A-1:0] addr;
      bit [W-1:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: set of registers awaiting a write, and the preferred requester.
   bit   m_pend[N];
   int   m_pref;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_pref = 0;
      exp_q.delete();
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0; rsv_valid = 0; flush = 0;
   endtask

   // Drive one cycle of stimulus, check the combinational outputs, predict the edge.
   task automatic drive_cycle(input bit v0, input bit [A-1:0] a0, input bit [W-1:0] d0,
                              input bit v1, input bit [A-1:0] a1, input bit [W-1:0] d1,
                              input bit rv, input bit [A-1:0] ra,
                              input bit [A-1:0] q1, input bit [A-1:0] q2, input bit fl);
      bit         v[2];
      bit [A-1:0] a[2];
      bit [W-1:0] d[2];
      int         w;
      exp_t       e;
      @(negedge clk);
      req0_valid = v0; req0_addr = a0; req0_val = d0;
      req1_valid = v1; req1_addr = a1; req1_val = d1;
      rsv_valid = rv; rsv_addr = ra; rs1_addr = q1; rs2_addr = q2; flush = fl;
      #1;
      v[0] = v0; v[1] = v1; a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
      w = -1;
      if (!fl) begin
         if (v[m_pref]) w = m_pref;
         else if (v[1 - m_pref]) w = 1 - m_pref;
      end
      check("ready0", req0_ready, w == 0);
      check("ready1", req1_ready, w == 1);
      check("rs1_busy", rs1_busy, m_pend[q1]);
      check("rs2_busy", rs2_busy, m_pend[q2]);
      e.we = (w >= 0) && (a[w < 0 ? 0 : w] != 0);
      e.addr = (w >= 0) ? a[w] : '0;
      e.val  = (w >= 0) ? d[w] : '0;
      exp_q.push_back(e);
      if (fl) begin
         foreach (m_pend[i]) m_pend[i] = 1'b0;
      end else begin
         if (w >= 0) begin
            m_pend[a[w]] = 1'b0;
            m_pref = 1 - w;
         end
         if (rv && ra != 0) m_pend[ra] = 1'b1;
      end
   endtask

   // Assert reset between edges just after a write appears on rd_*, check it drops at once.
   task automatic mid_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      idle_inputs();
      #1;
      check("rst_rd_we", rd_we, 1'b0);
      check("rst_rd_addr", rd_addr, '0);
      check("rst_rd_val", rd_val, '0);
      check("rst_busy", rs1_busy | rs2_busy, 1'b0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Monitor: one edge after each predicted cycle, compare the write port.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n !== 1'b1) continue;
         if (exp_q.size() == 0) begin
            check("rd_we_idle", rd_we, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("rd_we", rd_we, e.we);
            if (e.we) begin
               check("rd_addr", rd_addr, e.addr);
               check("rd_val", rd_val, e.val);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      req0_valid = 1; req0_addr = 5; req0_val = 32'hA;
      req1_valid = 1; req1_addr = 6; req1_val = 32'hB;
      rsv_valid = 0; rsv_addr = 0; rs1_addr = 7; rs2_addr = 9; flush = 0;
      model_reset();
      #2;
      check("reset_rd_we", rd_we, 1'b0);
      check("reset_rd_addr", rd_addr, '0);
      check("reset_rd_val", rd_val, '0);
      check("reset_busy1", rs1_busy, 1'b0);
      check("reset_busy2", rs2_busy, 1'b0);
      check("reset_ready0", req0_ready, 1'b1);
      check("reset_ready1", req1_ready, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      idle_inputs();
      #2;
      rst_n = 1'b1;

      // Both requesters continuously valid: grants alternate 0,1,0,1 from requester 0.
      for (int i = 0; i < 6; i++)
         drive_cycle(1, 5, 32'hA, 1, 6, 32'hB, 0, 0, 5, 6, 0);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reserve x7, observe busy, then the LSU completes x7.
      drive_cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
      drive_cycle(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0, 0);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 0);

      // Write to x0 is accepted but produces no register-file write.
      drive_cycle(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0);
      drive_cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Same-edge reserve and write of x9: the reservation survives.
      drive_cycle(1, 9, 32'h99, 0, 0, 0, 1, 9, 0, 9, 0);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);

      // Reserve x3, x4, then flush with a pending request.
      drive_cycle(0, 0, 0, 0, 0, 0, 1, 3, 3, 4, 0);
      drive_cycle(0, 0, 0, 0, 0, 0, 1, 4, 3, 4, 0);
      drive_cycle(1, 3, 32'h33, 0, 0, 0, 1, 5, 3, 4, 1);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 0);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 5, 0);

      // Reset between edges during an active write, then a lone LSU request.
      drive_cycle(1, 12, 32'h1234_5678, 0, 0, 0, 0, 0, 12, 9, 0);
      mid_reset();
      drive_cycle(0, 0, 0, 1, 13, 32'hCAFE, 0, 0, 9, 13, 0);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 13, 0);

      // Randomized traffic over a small address window to provoke collisions.
      for (int i = 0; i < 3000; i++) begin
         bit [A-1:0] lim;
         lim = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
         drive_cycle($urandom_range(0, 2) != 0, A'($urandom_range(0, lim)), $urandom,
                     $urandom_range(0, 2) != 0, A'($urandom_range(0, lim)), $urandom,
                     $urandom_range(0, 2) == 0, A'($urandom_range(0, lim)),
                     A'($urandom_range(0, lim)), A'($urandom_range(0, lim)),
                     $urandom_range(0, 19) == 0);
         if (i % 1000 == 999) mid_reset();
      end

      @(negedge clk);
      idle_inputs();
      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
